// File: rtl/debounce_pkg.sv
// Shared definitions for input filters: FSM state encoding and default filter sizing.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW   = 2'd0,
    S_CHK_H = 2'd1,
    S_HIGH  = 2'd2,
    S_CHK_L = 2'd3
  } state_t;

  localparam int DEF_STABLE_CYC = 4;
  localparam int DEF_CNT_W      = 8;

  // Timer width for a given stability length; at least one bit.
  function automatic int timer_w(input int stable_cyc);
    return (stable_cyc > 2) ? $clog2(stable_cyc) : 1;
  endfunction

endpackage

// File: rtl/debounce_timer.sv
// Stability timer: clear to 0, load to 1, or increment; flags the terminal count.
module debounce_timer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYC = DEF_STABLE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic term
);

  localparam int TW = timer_w(STABLE_CYC);
  localparam logic [TW-1:0] TERM_VAL = TW'(STABLE_CYC - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(1);
    end else if (inc && (count != TERM_VAL)) begin
      count <= count + TW'(1);
    end
  end

  assign term = (count == TERM_VAL);

endmodule

// File: rtl/debounce_edge.sv
// Debounces a registered 1-bit input; emits a clean level, rise/fall pulses
// and a wrapping count of accepted rising edges.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYC = DEF_STABLE_CYC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic             clr_cnt,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt
);

  state_t state_q;
  state_t state_d;
  logic   tmr_clr;
  logic   tmr_load;
  logic   tmr_inc;
  logic   tmr_term;
  logic   acc_rise;
  logic   acc_fall;

  debounce_timer #(
    .STABLE_CYC(STABLE_CYC)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .load (tmr_load),
    .inc  (tmr_inc),
    .term (tmr_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOW;
    end else begin
      state_q <= state_d;
    end
  end

  // A check state that sees the old value again aborts and clears the timer.
  always_comb begin
    state_d  = state_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_inc  = 1'b0;
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    case (state_q)
      S_LOW: begin
        if (d_in) begin
          state_d  = S_CHK_H;
          tmr_load = 1'b1;
        end
      end
      S_CHK_H: begin
        if (!d_in) begin
          state_d = S_LOW;
          tmr_clr = 1'b1;
        end else if (tmr_term) begin
          state_d  = S_HIGH;
          tmr_clr  = 1'b1;
          acc_rise = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_HIGH: begin
        if (!d_in) begin
          state_d  = S_CHK_L;
          tmr_load = 1'b1;
        end
      end
      S_CHK_L: begin
        if (d_in) begin
          state_d = S_HIGH;
          tmr_clr = 1'b1;
        end else if (tmr_term) begin
          state_d  = S_LOW;
          tmr_clr  = 1'b1;
          acc_fall = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        tmr_clr = 1'b1;
      end
    endcase
  end

  // Clear takes priority, but a same-edge accepted rise still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      rise <= acc_rise;
      fall <= acc_fall;
      if (acc_rise) begin
        level <= 1'b1;
      end else if (acc_fall) begin
        level <= 1'b0;
      end
      if (clr_cnt) begin
        edge_cnt <= acc_rise ? CNT_W'(1) : '0;
      end else if (acc_rise) begin
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
    end
  end

endmodule
